vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Parametrised VGA timing generator. It succeeds the fixed 800x600 sync block that is driven by a single 40 MHz pixel clock. Generates hsync/vsync, an active-video qualifier, pixel coordinates and frame/line strobes for any timing mode. A pixel clock-enable lets it run from a faster system clock, for example 80 MHz with ce every 2nd cycle. Sits between the clock/reset source and the pixel-drawing (control) logic.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 11, width of counters and x/y; elaboration error if H_TOTAL or V_TOTAL > 2**CNT_W

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pix_ce  in  1  pixel advance enable; tie 1 when clk is the pixel clock
hsync_sig  out  1  horizontal sync, polarity per HS_POL
vsync_sig  out  1  vertical sync, polarity per VS_POL
is_ready  out  1  active-video qualifier (x < H_ACTIVE and y < V_ACTIVE)
x  out  CNT_W  pixel column; 0 outside active video
y  out  CNT_W  pixel row; 0 outside active video
line_start  out  1  one-clk strobe: first pixel of any line (h = 0)
frame_start  out  1  one-clk strobe: pixel (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (default 1056); V_TOTAL likewise (default 628).
- Region order per axis: active, front porch, sync, back porch.
- Internal h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, advanced only on clk edges with pix_ce = 1.
- h_cnt wrap: at H_TOTAL-1 it goes to 0 and v_cnt increments.
- v_cnt wrap: at V_TOTAL-1 with h wrap, both go to 0.
- All outputs are registered. They are decoded from the counter value being entered on a pix_ce edge, so outputs for pixel (h,v) appear in the clk cycle after the edge that selects it.
- hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 840..967).
- vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default 601..604), for whole lines including their horizontal blanking.
- While pix_ce = 0: hsync_sig, vsync_sig, is_ready, x and y hold their values; line_start and frame_start drop to 0, so strobes are exactly one clk wide.
- Reset values, applied on any clk edge with rst = 1 regardless of pix_ce:
  - counters 0
  - hsync_sig = ~HS_POL, vsync_sig = ~VS_POL
  - is_ready = 0, x = 0, y = 0, line_start = 0, frame_start = 0
- First pix_ce edge after reset presents pixel (0,0): is_ready = 1, line_start = 1, frame_start = 1.
- Reset mid-frame aborts the frame; no partial-line completion.
- rst has priority over pix_ce.
- Arithmetic is unsigned CNT_W bits; no counter ever exceeds TOTAL-1.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds outputs red_sig, green_sig, blue_sig (1 bit each, registered, same timing as is_ready).
- Pattern is 8 vertical colour bars of H_ACTIVE/8 pixels each, in order white, yellow, cyan, green, magenta, red, blue, black (rgb 111,110,011,010,101,100,001,000).
- Bar index comes from a 3-bit counter plus a bar-width counter, reset at line start. No divider.
- Colour outputs are 000 outside active video and at reset.
- Elaboration error if H_ACTIVE is not divisible by 8.
- Undefined: the three ports and their logic do not exist.

Decomposition:
- Package vga_timing_pkg holds:
  - localparams for the default 800x600@60 timing (the 8 values above)
  - CNT_W default
  - function computing TOTAL from active/fp/sync/bp
  - region enum (ACTIVE, FP, SYNC, BP)
- One sub-module, vga_axis_counter, instantiated twice (h with enable = pix_ce, v with enable = pix_ce & h wrap). It provides wrap counting, a terminal-count flag and decoded region/sync.

Test Plan:
- Reset then pix_ce = 1 constantly -> first cycle after reset release: x = 0, y = 0, is_ready = 1, frame_start = 1; line_start repeats every 1056 clks; frame_start repeats every 663168 clks.
- Count hsync per line (defaults) -> exactly 128 consecutive active cycles, beginning 840 pixels after line_start; is_ready high for exactly 800 pixels per line; x runs 0..799 then returns to 0.
- vsync check -> active for exactly 4 lines (4224 clks), starting at line 601; is_ready = 0 throughout lines 600..627; y runs 0..599.
- pix_ce every 2nd clk (80 MHz case) -> all periods double (line 2112 clks); strobes still 1 clk wide; x/y/sync hold on non-ce cycles.
- Small mode (H 8/1/2/1, V 4/1/1/1, HS_POL = 0, VS_POL = 0, CNT_W = 4) -> H_TOTAL 12; hsync low at h = 9,10; frame of 84 pixels; assert rst at pixel (5,2) -> next clk all outputs at reset values; the first ce edge after rst deasserts presents (0,0).
- With VGA_TEST_PATTERN_EN -> rgb = 111 at x = 0..99, 110 at x = 100..199, ..., 000 at x = 700..799; 000 during blanking.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 800x600@60 timing constants, total helper and axis region type
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP = 40;
  localparam int DEF_H_SYNC = 128;
  localparam int DEF_H_BP = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP = 1;
  localparam int DEF_V_SYNC = 4;
  localparam int DEF_V_BP = 23;
  localparam int DEF_CNT_W = 11;
  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_t;
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter for one axis with terminal flag and region decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = DEF_CNT_W,
  parameter int A_LEN = DEF_H_ACTIVE,
  parameter int F_LEN = DEF_H_FP,
  parameter int S_LEN = DEF_H_SYNC,
  parameter int B_LEN = DEF_H_BP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc,
  output region_t      region
);
  localparam int TOT = total(A_LEN, F_LEN, S_LEN, B_LEN);
  localparam logic [W-1:0] LAST = W'(TOT - 1);
  int c;
  assign tc = cnt == LAST;
  // position counter: wraps to 0 after the last position of the axis
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
  // region of the current position, compared in 32-bit to avoid boundary truncation
  always_comb begin
    c = int'(cnt);
    region = c < A_LEN ? ACTIVE :
             c < A_LEN + F_LEN ? FP :
             c < A_LEN + F_LEN + S_LEN ? SYNC : BP;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator with pixel clock-enable;
// optional colour-bar test pattern outputs when VGA_TEST_PATTERN_EN is defined
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic             hsync_sig,
  output logic             vsync_sig,
  output logic             is_ready,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic             red_sig,
  output logic             green_sig,
  output logic             blue_sig
`endif
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (H_TOTAL > (1 << CNT_W)) begin : g_h_err
    $error("vga_sync_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_err
    $error("vga_sync_gen: V_TOTAL does not fit in CNT_W bits");
  end
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_tc, v_tc, act;
  logic unused_v_tc;
  region_t h_rgn, v_rgn;
  assign unused_v_tc = v_tc;
  assign act = h_rgn == ACTIVE && v_rgn == ACTIVE;
  vga_axis_counter #(
    .W(CNT_W), .A_LEN(H_ACTIVE), .F_LEN(H_FP), .S_LEN(H_SYNC), .B_LEN(H_BP)
  ) u_h (
    .clk(clk), .rst(rst), .en(pix_ce), .cnt(h_cnt), .tc(h_tc), .region(h_rgn)
  );
  vga_axis_counter #(
    .W(CNT_W), .A_LEN(V_ACTIVE), .F_LEN(V_FP), .S_LEN(V_SYNC), .B_LEN(V_BP)
  ) u_v (
    .clk(clk), .rst(rst), .en(pix_ce & h_tc), .cnt(v_cnt), .tc(v_tc), .region(v_rgn)
  );
  // register outputs decoded from the pixel being entered; strobes only on ce edges
  always_ff @(posedge clk)
    if (rst) begin
      hsync_sig <= ~HS_POL;
      vsync_sig <= ~VS_POL;
      is_ready <= 1'b0;
      x <= '0;
      y <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start <= pix_ce && h_cnt == '0;
      frame_start <= pix_ce && h_cnt == '0 && v_cnt == '0;
      if (pix_ce) begin
        hsync_sig <= h_rgn == SYNC ? HS_POL : ~HS_POL;
        vsync_sig <= v_rgn == SYNC ? VS_POL : ~VS_POL;
        is_ready <= act;
        x <= act ? h_cnt : '0;
        y <= act ? v_cnt : '0;
      end
    end
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  if (H_ACTIVE % 8 != 0) begin : g_bar_err
    $error("vga_sync_gen: H_ACTIVE must be divisible by 8");
  end
  logic [2:0] bar_idx, bar_idx_n;
  logic [CNT_W-1:0] bar_cnt, bar_cnt_n;
  // bar position of the pixel being entered, restarting at each line start
  always_comb begin
    bar_idx_n = h_cnt == '0 ? 3'd0 : bar_cnt == BAR_LAST ? bar_idx + 3'd1 : bar_idx;
    bar_cnt_n = h_cnt == '0 || bar_cnt == BAR_LAST ? '0 : bar_cnt + CNT_W'(1);
  end
  // bar tracking and colour registers: white,yellow,cyan,green,magenta,red,blue,black
  always_ff @(posedge clk)
    if (rst) begin
      bar_idx <= 3'd0;
      bar_cnt <= '0;
      red_sig <= 1'b0;
      green_sig <= 1'b0;
      blue_sig <= 1'b0;
    end else if (pix_ce) begin
      bar_idx <= bar_idx_n;
      bar_cnt <= bar_cnt_n;
      red_sig <= act & ~bar_idx_n[1];
      green_sig <= act & ~bar_idx_n[2];
      blue_sig <= act & ~bar_idx_n[0];
    end
`endif
endmodule
